// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// baud-period helper used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  function automatic int unsigned clocks_per_baud(input int unsigned sysclock,
                                                  input int unsigned baudrate);
    return sysclock / baudrate;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side UART bundle: the serial line in, and the byte/strobe/busy
// outputs presented to the consumer.
interface uart_rx_if;

  logic                                 i_uart_rx;
  logic [uart_pkg::UART_DATA_BITS-1:0]  o_data;
  logic                                 o_valid;
  logic                                 o_frame_err;
  logic                                 o_busy;

  // master drives the line and consumes bytes; slave is the receiver itself
  modport master (output i_uart_rx, input o_data, o_valid, o_frame_err, o_busy);
  modport slave  (input i_uart_rx, output o_data, o_valid, o_frame_err, o_busy);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a
// selectable reset level so idle-high and idle-low lines both start quiet.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value; blocking here would collapse the two stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling driven by a reloadable baud down-counter,
// with a one-cycle strobe for each good byte and for each framing error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUDRATE = 115200,
  parameter int unsigned SYSCLOCK = 100000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  uart_rx_if.slave   bus
);

  localparam int unsigned CLOCKS_PER_BAUD = clocks_per_baud(SYSCLOCK, BAUDRATE);
  localparam int unsigned HALF_BAUD       = CLOCKS_PER_BAUD / 2;
  localparam logic [31:0] FULL_LOAD       = 32'(CLOCKS_PER_BAUD - 1);
  localparam logic [31:0] HALF_LOAD       = 32'(HALF_BAUD - 1);
  localparam logic [2:0]  LAST_BIT        = 3'(UART_DATA_BITS - 1);

  if (CLOCKS_PER_BAUD < 4) begin : g_baud_check
    $error("uart_rx: SYSCLOCK/BAUDRATE must be at least 4");
  end

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (bus.i_uart_rx),
    .q   (rx_s)
  );

  uart_rx_state_t              state, state_nx;
  logic [31:0]                 baud_cnt, baud_cnt_nx;
  logic [2:0]                  bit_cnt, bit_cnt_nx;
  logic [UART_DATA_BITS-1:0]   shift, shift_nx;
  logic [UART_DATA_BITS-1:0]   data, data_nx;
  logic                        valid, valid_nx;
  logic                        frame_err, frame_err_nx;
  logic                        tick;

  assign tick = (baud_cnt == 32'd0);

  // NOTE: every signal written here gets a default before the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx     = state;
    baud_cnt_nx  = tick ? baud_cnt : baud_cnt - 32'd1;
    bit_cnt_nx   = bit_cnt;
    shift_nx     = shift;
    data_nx      = data;
    valid_nx     = 1'b0;
    frame_err_nx = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          baud_cnt_nx = HALF_LOAD;
          state_nx    = START;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            baud_cnt_nx = FULL_LOAD;
            bit_cnt_nx  = 3'd0;
            state_nx    = DATA;
          end else begin
            state_nx    = IDLE;   // start bit did not survive to mid-bit
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_nx    = {rx_s, shift[UART_DATA_BITS-1:1]};
          baud_cnt_nx = FULL_LOAD;
          if (bit_cnt == LAST_BIT) state_nx = STOP;
          else                     bit_cnt_nx = bit_cnt + 3'd1;
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            data_nx      = shift;
            valid_nx     = 1'b1;
            state_nx     = IDLE;
          end else begin
            frame_err_nx = 1'b1;
            state_nx     = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // a held-low line (break) must not restart reception until it recovers
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      baud_cnt  <= 32'd0;
      bit_cnt   <= 3'd0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      baud_cnt  <= baud_cnt_nx;
      bit_cnt   <= bit_cnt_nx;
      shift     <= shift_nx;
      data      <= data_nx;
      valid     <= valid_nx;
      frame_err <= frame_err_nx;
    end
  end

  assign bus.o_data      = data;
  assign bus.o_valid     = valid;
  assign bus.o_frame_err = frame_err;
  assign bus.o_busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks per bit: clean, back-to-back,
// glitch, framing error, mid-frame reset and +4% baud skew.
module tb_uart_rx;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if bus();

  uart_rx #(
    .BAUDRATE (12500000),
    .SYSCLOCK (100000000)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // cycle stamp = number of rising edges seen so far
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // strobe monitor, sampled on the falling edge
  logic [7:0]  vdata_q[$];
  int unsigned vcyc_q[$];
  int          ferr_cnt    = 0;
  int          rule_viol   = 0;
  logic        prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (bus.o_valid) begin
      vdata_q.push_back(bus.o_data);
      vcyc_q.push_back(cyc);
    end
    if (bus.o_frame_err) ferr_cnt <= ferr_cnt + 1;
    if (bus.o_valid && bus.o_frame_err) rule_viol <= rule_viol + 1;
    if ((bus.o_valid || bus.o_frame_err) && prev_strobe) rule_viol <= rule_viol + 1;
    prev_strobe <= bus.o_valid || bus.o_frame_err;
  end

  // Drives one 8N1 frame starting at a falling edge; p10 = bit period in tenths
  // of a clock, bit k starting at floor(k*p10/10) cycles after the start edge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int p10);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      bus.i_uart_rx = bits[k];
      repeat (((k + 1) * p10) / 10 - (k * p10) / 10) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] vdata_at(input int i);
    return (vdata_q.size() > i) ? 32'(vdata_q[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] vcyc_at(input int i);
    return (vcyc_q.size() > i) ? 32'(vcyc_q[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_q();
    vdata_q.delete();
    vcyc_q.delete();
  endtask

  int unsigned fall_cyc;
  int          ferr_base;
  int          busy_hi;

  initial begin
    bus.i_uart_rx = 1'b1;
    rst = 1'b1;
    idle(5);
    check("rst_data",  32'(bus.o_data), 32'h00);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_ferr",  32'(bus.o_frame_err), 32'd0);
    check("rst_busy",  32'(bus.o_busy), 32'd0);
    rst = 1'b0;
    idle(10);

    // clean 0x55: strobe 2 (sync) + 4 (half bit) + 72 (9 bits) + 1 (register)
    clear_q();
    ferr_base = ferr_cnt;
    fall_cyc  = cyc;
    send_frame(8'h55, 1'b1, 80);
    idle(10);
    #1;
    check("c55_count",   32'(vdata_q.size()), 32'd1);
    check("c55_data",    vdata_at(0), 32'h55);
    check("c55_latency", vcyc_at(0) - 32'(fall_cyc), 32'd79);
    check("c55_no_ferr", 32'(ferr_cnt - ferr_base), 32'd0);

    // back-to-back 0xA5, 0x3C with no idle gap
    clear_q();
    send_frame(8'hA5, 1'b1, 80);
    send_frame(8'h3C, 1'b1, 80);
    idle(10);
    #1;
    check("b2b_count",   32'(vdata_q.size()), 32'd2);
    check("b2b_data0",   vdata_at(0), 32'hA5);
    check("b2b_data1",   vdata_at(1), 32'h3C);
    check("b2b_spacing", vcyc_at(1) - vcyc_at(0), 32'd80);

    // start glitch: line low for two cycles
    clear_q();
    ferr_base = ferr_cnt;
    busy_hi   = 0;
    for (int i = 0; i < 14; i++) begin
      bus.i_uart_rx = (i < 2) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (bus.o_busy) busy_hi++;
    end
    #1;
    check("glitch_busy_cycles", 32'(busy_hi), 32'd4);
    check("glitch_busy_end",    32'(bus.o_busy), 32'd0);
    check("glitch_no_strobe",   32'(vdata_q.size() + (ferr_cnt - ferr_base)), 32'd0);

    // framing error: 0xFF with low stop bit, line then held low 40 cycles
    clear_q();
    ferr_base = ferr_cnt;
    send_frame(8'hFF, 1'b0, 80);
    idle(40);
    bus.i_uart_rx = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("ferr_busy_%0d", i), 32'(bus.o_busy), (i < 3) ? 32'd1 : 32'd0);
    end
    idle(20);
    #1;
    check("ferr_pulses",   32'(ferr_cnt - ferr_base), 32'd1);
    check("ferr_no_valid", 32'(vdata_q.size()), 32'd0);
    check("ferr_data_kept", 32'(bus.o_data), 32'h3C);

    // reset after data bit 3 of a frame, then a clean 0x81
    clear_q();
    ferr_base = ferr_cnt;
    bus.i_uart_rx = 1'b0;
    idle(40);
    rst = 1'b1;
    bus.i_uart_rx = 1'b1;
    idle(1);
    check("mrst_data",  32'(bus.o_data), 32'h00);
    check("mrst_valid", 32'(bus.o_valid), 32'd0);
    check("mrst_ferr",  32'(bus.o_frame_err), 32'd0);
    check("mrst_busy",  32'(bus.o_busy), 32'd0);
    rst = 1'b0;
    idle(20);
    send_frame(8'h81, 1'b1, 80);
    idle(10);
    #1;
    check("mrst_count",   32'(vdata_q.size()), 32'd1);
    check("mrst_data81",  vdata_at(0), 32'h81);
    check("mrst_no_ferr", 32'(ferr_cnt - ferr_base), 32'd0);

    // +4% slow transmitter: 8.3 clocks per bit
    clear_q();
    send_frame(8'hC3, 1'b1, 83);
    idle(10);
    #1;
    check("skew_count", 32'(vdata_q.size()), 32'd1);
    check("skew_data",  vdata_at(0), 32'hC3);

    check("strobe_rules", 32'(rule_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
